uart_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing one UART TX controller between NUM_REQ byte requesters.
//  - Latches the granted requester's byte and drives the TX controller's ready/byte inputs.
//  - Tracks the frame through to o_Tx_Done, then reports completion to the owner.
//  - Sits between client logic and the TX controller inside the UART controller top.
//  - A watchdog recovers the block if the TX controller never finishes a frame.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and a modular increment helper.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {ARB_IDLE, ARB_LAUNCH, ARB_BUSY} uart_arb_state_t;

    // Explicit wrap so non-power-of-2 ring sizes stay in range.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request scanning ptr, ptr+1, .. modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int cand;

    // Scan from the farthest offset down so the nearest hit is written last and wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (req[IDX_W'(cand)]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX controller among NUM_REQ byte requesters, with watchdog.
// Optional macro UART_ARB_LOCK_EN adds i_Lock so an owner can keep the transmitter across frames.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             i_Req,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] i_Req_Byte,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             i_Lock,
`endif
    output logic [NUM_REQ-1:0]             o_Ack,
    output logic [NUM_REQ-1:0]             o_Done,
    output logic                           o_Timeout,
    output logic                           o_Busy,
    output logic                           o_Tx_Ready,
    output logic [UART_BYTE_W-1:0]         o_Tx_Byte,
    input  logic                           i_Tx_Active,
    input  logic                           i_Tx_Done,
    output logic [1:0]                     o_Dbg_State
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    uart_arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d, ptr_q, ptr_d, next_ptr;
    logic [WD_W-1:0]          wd_q, wd_d;
    logic [UART_BYTE_W-1:0]   byte_d;
    logic [NUM_REQ-1:0]       ack_d, done_d;
    logic                     tmo_d, rdy_d;
    logic                     grant, end_done, end_tmo, pick_valid;
    logic [IDX_W-1:0]         grant_idx, pick_idx;
    logic                     relock_q, relock_d;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (i_Req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign next_ptr    = IDX_W'(wrap_inc(int'(owner_q), NUM_REQ));
    assign o_Busy      = (state_q != ARB_IDLE);
    assign o_Dbg_State = state_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        byte_d    = o_Tx_Byte;
        ack_d     = '0;
        done_d    = '0;
        tmo_d     = 1'b0;
        rdy_d     = o_Tx_Ready;
        relock_d  = relock_q;
        grant     = 1'b0;
        grant_idx = pick_idx;
        end_done  = 1'b0;
        end_tmo   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                wd_d     = '0;
                relock_d = 1'b0;
`ifdef UART_ARB_LOCK_EN
                if (relock_q && i_Req[owner_q]) begin
                    grant     = 1'b1;
                    grant_idx = owner_q;
                end else
`endif
                if (pick_valid) grant = 1'b1;
                if (grant) begin
                    owner_d          = grant_idx;
                    byte_d           = i_Req_Byte[int'(grant_idx)*UART_BYTE_W +: UART_BYTE_W];
                    ack_d[grant_idx] = 1'b1;
                    rdy_d            = 1'b1;
                    state_d          = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: begin
                if (wd_q != '1) wd_d = wd_q + 1'b1;
                // Done beats both the handshake and watchdog expiry.
                if (i_Tx_Active && i_Tx_Done) end_done = 1'b1;
                else if (wd_q == WD_LAST)     end_tmo  = 1'b1;
                else if (i_Tx_Active) begin
                    rdy_d   = 1'b0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (wd_q != '1) wd_d = wd_q + 1'b1;
                if (i_Tx_Done)            end_done = 1'b1;
                else if (wd_q == WD_LAST) end_tmo  = 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase

        if (end_done) begin
            done_d[owner_q] = 1'b1;
            rdy_d           = 1'b0;
            ptr_d           = next_ptr;
            state_d         = ARB_IDLE;
`ifdef UART_ARB_LOCK_EN
            if (i_Lock[owner_q] && i_Req[owner_q]) begin
                relock_d = 1'b1;
                ptr_d    = ptr_q;
            end
`endif
        end
        if (end_tmo) begin
            tmo_d   = 1'b1;
            rdy_d   = 1'b0;
            ptr_d   = next_ptr;
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            wd_q       <= '0;
            relock_q   <= 1'b0;
            o_Ack      <= '0;
            o_Done     <= '0;
            o_Timeout  <= 1'b0;
            o_Tx_Ready <= 1'b0;
            o_Tx_Byte  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            wd_q       <= wd_d;
            relock_q   <= relock_d;
            o_Ack      <= ack_d;
            o_Done     <= done_d;
            o_Timeout  <= tmo_d;
            o_Tx_Ready <= rdy_d;
            o_Tx_Byte  <= byte_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a 4-requester and a 3-requester instance against a transaction-level model.
module tb_uart_tx_arbiter;

    localparam int T4 = 200;
    localparam int T3 = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req_v;
    logic [63:0] byte_v;
    logic [7:0]  lock_v;
    logic        active_v, done_v;
    logic        use3;

    logic [3:0] ack4, done4;
    logic [2:0] ack3, done3;
    logic       tmo4, busy4, rdy4, tmo3, busy3, rdy3;
    logic [7:0] txb4, txb3;
    logic [1:0] st4, st3;

    logic [7:0] ack_o, done_o, txb_o;
    logic       tmo_o, busy_o, rdy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m, last_owner, n_req;
    bit relock_m;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(T4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .i_Req       (use3 ? 4'b0 : req_v[3:0]),
        .i_Req_Byte  (byte_v[31:0]),
`ifdef UART_ARB_LOCK_EN
        .i_Lock      (use3 ? 4'b0 : lock_v[3:0]),
`endif
        .o_Ack       (ack4),
        .o_Done      (done4),
        .o_Timeout   (tmo4),
        .o_Busy      (busy4),
        .o_Tx_Ready  (rdy4),
        .o_Tx_Byte   (txb4),
        .i_Tx_Active (!use3 && active_v),
        .i_Tx_Done   (!use3 && done_v),
        .o_Dbg_State (st4)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(T3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .i_Req       (use3 ? req_v[2:0] : 3'b0),
        .i_Req_Byte  (byte_v[23:0]),
`ifdef UART_ARB_LOCK_EN
        .i_Lock      (use3 ? lock_v[2:0] : 3'b0),
`endif
        .o_Ack       (ack3),
        .o_Done      (done3),
        .o_Timeout   (tmo3),
        .o_Busy      (busy3),
        .o_Tx_Ready  (rdy3),
        .o_Tx_Byte   (txb3),
        .i_Tx_Active (use3 && active_v),
        .i_Tx_Done   (use3 && done_v),
        .o_Dbg_State (st3)
    );

    assign ack_o  = use3 ? {5'b0, ack3}  : {4'b0, ack4};
    assign done_o = use3 ? {5'b0, done3} : {4'b0, done4};
    assign txb_o  = use3 ? txb3 : txb4;
    assign tmo_o  = use3 ? tmo3 : tmo4;
    assign busy_o = use3 ? busy3 : busy4;
    assign rdy_o  = use3 ? rdy3 : rdy4;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: locked owner first, else first requester at or after ptr (mod n).
    function automatic int model_pick(input logic [7:0] r);
        if (relock_m && r[last_owner]) return last_owner;
        for (int off = 0; off < n_req; off++)
            if (r[(ptr_m + off) % n_req]) return (ptr_m + off) % n_req;
        return -1;
    endfunction

    task automatic model_finish(input int owner, input bit timed_out);
        relock_m   = 1'b0;
        last_owner = owner;
`ifdef UART_ARB_LOCK_EN
        if (!timed_out && lock_v[owner] && req_v[owner]) begin
            relock_m = 1'b1;
            return;
        end
`endif
        ptr_m = (owner + 1) % n_req;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req_v    = '0;
        active_v = 1'b0;
        done_v   = 1'b0;
        lock_v   = '0;
        repeat (2) begin @(posedge clk); #1; end
        reset    = 1'b0;
        ptr_m    = 0;
        relock_m = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_ack(output int owner);
        int lat;
        owner = model_pick(req_v);
        lat   = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (ack_o == 0 && lat < 8);
        check_eq("ack_latency", lat, 1);
        check_eq("ack_onehot", ack_o, 32'(1) << owner);
        check_eq("tx_ready_launch", rdy_o, 1);
        check_eq("busy_launch", busy_o, 1);
    endtask

    task automatic run_frame(input int act_dly, input int done_dly, input bit drop);
        int owner;
        wait_ack(owner);
        exp_q.push_back(byte_v[owner*8 +: 8]);
        if (drop) req_v[owner] = 1'b0;
        @(posedge clk); #1;
        check_eq("ack_pulse_width", ack_o, 0);
        check_eq("tx_ready_hold", rdy_o, 1);
        repeat (act_dly) begin @(posedge clk); #1; end
        check_eq("tx_byte", txb_o, exp_q.pop_front());
        if (done_dly == 0) begin
            active_v = 1'b1;
            done_v   = 1'b1;
            @(posedge clk); #1;
        end else begin
            active_v = 1'b1;
            @(posedge clk); #1;
            check_eq("tx_ready_drop", rdy_o, 0);
            check_eq("busy_frame", busy_o, 1);
            repeat (done_dly - 1) begin @(posedge clk); #1; end
            check_eq("done_early", done_o, 0);
            done_v = 1'b1;
            @(posedge clk); #1;
        end
        done_v   = 1'b0;
        active_v = 1'b0;
        check_eq("done_onehot", done_o, 32'(1) << owner);
        check_eq("busy_after_done", busy_o, 0);
        check_eq("no_timeout", tmo_o, 0);
        check_eq("tx_ready_idle", rdy_o, 0);
        model_finish(owner, 1'b0);
    endtask

    task automatic run_timeout(input int act_dly, input int tmo_cycles);
        int owner, cnt;
        bit saw_done;
        wait_ack(owner);
        check_eq("tmo_tx_byte", txb_o, byte_v[owner*8 +: 8]);
        req_v    = '0;
        cnt      = 0;
        saw_done = 1'b0;
        do begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == act_dly) active_v = 1'b1;
            if (done_o != 0) saw_done = 1'b1;
        end while (tmo_o == 0 && cnt < 4 * tmo_cycles);
        check_eq("timeout_cycle", cnt, tmo_cycles);
        check_eq("timeout_no_done", 32'(saw_done), 0);
        check_eq("timeout_busy", busy_o, 0);
        check_eq("timeout_ready", rdy_o, 0);
        active_v = 1'b0;
        @(posedge clk); #1;
        check_eq("timeout_pulse_width", tmo_o, 0);
        model_finish(owner, 1'b1);
    endtask

    initial begin
        int owner;
        use3   = 1'b0;
        n_req  = 4;
        byte_v = '0;
        last_owner = 0;
        do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("reset_ack", ack_o, 0);
        check_eq("reset_done", done_o, 0);
        check_eq("reset_timeout", tmo_o, 0);
        check_eq("reset_busy", busy_o, 0);
        check_eq("reset_ready", rdy_o, 0);
        check_eq("reset_byte", txb_o, 0);
        check_eq("reset_state", st4, 0);
        reset = 1'b0;

        // Single frame, then confirm the pointer moved to 1.
        req_v = 8'h01; byte_v[7:0] = 8'hA5;
        run_frame(3, 100, 1'b1);
        req_v = 8'h03; byte_v[15:8] = 8'h5A;
        run_frame(1, 5, 1'b1);
        req_v = '0;

        // All four held: rotation 0,1,2,3,0.
        do_reset();
        byte_v[31:0] = 32'h44332211;
        req_v = 8'h0F;
        repeat (5) run_frame(2, 10, 1'b0);
        req_v = '0;

        // Active and done together while launching.
        req_v = 8'h04;
        run_frame(2, 0, 1'b1);

        for (int it = 0; it < 20; it++) begin
            req_v  = 8'($urandom_range(1, 15));
            byte_v = {$urandom, $urandom};
            run_frame($urandom_range(0, 4), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
        end
        req_v = '0;
        @(posedge clk); #1;

        // Reset in the middle of a frame.
        req_v = 8'h08;
        wait_ack(owner);
        req_v = '0;
        active_v = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midreset_ack", ack_o, 0);
        check_eq("midreset_done", done_o, 0);
        check_eq("midreset_timeout", tmo_o, 0);
        check_eq("midreset_busy", busy_o, 0);
        check_eq("midreset_ready", rdy_o, 0);
        check_eq("midreset_byte", txb_o, 0);
        reset = 1'b0; active_v = 1'b0;
        ptr_m = 0; relock_m = 1'b0;
        req_v = 8'h02; byte_v[15:8] = 8'hC3;
        run_frame(1, 3, 1'b1);
        req_v = '0;

        // Three requesters: pointer wrap and watchdog.
        do_reset();
        use3 = 1'b1; n_req = 3;
        byte_v[23:0] = 24'h332211;
        req_v = 8'h02; run_frame(1, 4, 1'b1);
        req_v = 8'h03; run_frame(1, 4, 1'b1);
        req_v = 8'h02; run_frame(0, 2, 1'b1);
        req_v = 8'h04; run_frame(2, 3, 1'b1);
        req_v = 8'h07; run_frame(1, 1, 1'b1);
        req_v = '0;
        req_v = 8'h01; run_timeout(2, T3);
        req_v = 8'h04; run_timeout(0, T3);
        req_v = 8'h06; run_frame(1, 6, 1'b1);
        req_v = '0;
        for (int it = 0; it < 8; it++) begin
            req_v  = 8'($urandom_range(1, 7));
            byte_v = {$urandom, $urandom};
            run_frame($urandom_range(0, 3), $urandom_range(0, 12), 1'b1);
            req_v = '0;
        end

`ifdef UART_ARB_LOCK_EN
        do_reset();
        use3 = 1'b0; n_req = 4;
        byte_v[31:0] = 32'hD4C3B2A1;
        req_v  = 8'h06;
        lock_v = 8'h02;
        repeat (3) run_frame(1, 4, 1'b0);
        check_eq("lock_regrant_owner", model_pick(req_v), 1);
        lock_v = '0;
        run_frame(1, 4, 1'b0);
        check_eq("lock_release_next", model_pick(req_v), 2);
        run_frame(1, 4, 1'b0);
        req_v = '0;
`endif

        repeat (3) begin @(posedge clk); #1; end
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
